// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side MAR/MDR registers plus a Moore FSM that sequences
// asynchronous SRAM read/write strobes with a programmable wait count.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Bus,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        Mem_R,
    input  logic        Mem_W,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] Data_to_SRAM,
    output logic        Data_OE,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_LATCH,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register loads and new requests are only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        case (state_q)
            IDLE: begin
                if (LD_MAR) mar_d = Bus;
                if (LD_MDR) mdr_d = Bus;
                if (Mem_R) begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_INIT;
                end else if (Mem_W) begin
                    state_d = WR_SETUP;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) state_d = RD_LATCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RD_LATCH: begin
                mdr_d   = Data_from_SRAM;
                state_d = DONE;
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_INIT;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the state register alone; WE_n and OE_n are
    // never low together because no state drives both.
    always_comb begin
        CE_n    = 1'b1;
        OE_n    = 1'b1;
        WE_n    = 1'b1;
        Data_OE = 1'b0;
        Done    = 1'b0;
        Busy    = (state_q != IDLE);
        case (state_q)
            RD_WAIT, RD_LATCH: begin
                CE_n = 1'b0;
                OE_n = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                CE_n    = 1'b0;
                Data_OE = 1'b1;
            end
            WR_PULSE: begin
                CE_n    = 1'b0;
                WE_n    = 1'b0;
                Data_OE = 1'b1;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    assign MAR          = mar_q;
    assign MDR          = mdr_q;
    assign Data_to_SRAM = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: three instances (WAIT_CYCLES 1, 2, 15)
// compared every cycle against a transaction-timeline reference model.
module tb_mem_access_ctrl;

   logic        Clk;
   logic        resetN;
   logic [15:0] bus;
   logic        ldMar;
   logic        ldMdr;
   logic        memR [3];
   logic        memW [3];
   logic [15:0] dfs;

   logic [15:0] marO [3];
   logic [15:0] mdrO [3];
   logic [15:0] dtsO [3];
   logic        dataOe [3];
   logic        ceN [3];
   logic        oeN [3];
   logic        weN [3];
   logic        busy [3];
   logic        done [3];

   int checkCount = 0;
   int passCount  = 0;

   // Reference model: kind 0 idle, 1 read, 2 write; age counts cycles into the access
   int          mKind [3];
   int          mAge  [3];
   logic [15:0] mMar  [3];
   logic [15:0] mMdr  [3];

   int cyc [3];
   int doneAt [3];
   int oeLow [3];
   int weLow [3];

   for (genvar g = 0; g < 3; g++) begin : gDut
      mem_access_ctrl #(.WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 2 : 15))) uDut (
         .Clk(Clk),
         .Reset_n(resetN),
         .Bus(bus),
         .LD_MAR(ldMar),
         .LD_MDR(ldMdr),
         .Mem_R(memR[g]),
         .Mem_W(memW[g]),
         .Data_from_SRAM(dfs),
         .MAR(marO[g]),
         .MDR(mdrO[g]),
         .Data_to_SRAM(dtsO[g]),
         .Data_OE(dataOe[g]),
         .CE_n(ceN[g]),
         .OE_n(oeN[g]),
         .WE_n(weN[g]),
         .Busy(busy[g]),
         .Done(done[g])
      );
   end

   // Free-running clock, 10 time-unit period
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic int wOf(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 2 : 15);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic modelReset();
      for (int g = 0; g < 3; g++) begin
         mKind[g] = 0;
         mAge[g]  = 0;
         mMar[g]  = 16'h0000;
         mMdr[g]  = 16'h0000;
      end
   endtask

   // A read lasts W+2 cycles (W strobe, 1 latch, 1 done), a write W+3
   task automatic modelStep();
      if (!resetN) begin
         modelReset();
      end else begin
         for (int g = 0; g < 3; g++) begin
            int w = wOf(g);
            if (mKind[g] != 0) begin
               if (mKind[g] == 1 && mAge[g] == w) mMdr[g] = dfs;
               mAge[g]++;
               if ((mKind[g] == 1 && mAge[g] == w + 2) || (mKind[g] == 2 && mAge[g] == w + 3))
                  mKind[g] = 0;
            end else begin
               if (ldMar) mMar[g] = bus;
               if (ldMdr) mMdr[g] = bus;
               if (memR[g]) begin
                  mKind[g] = 1;
                  mAge[g]  = 0;
               end else if (memW[g]) begin
                  mKind[g] = 2;
                  mAge[g]  = 0;
               end
            end
         end
      end
   endtask

   task automatic checkAll();
      for (int g = 0; g < 3; g++) begin
         int   w = wOf(g);
         logic eCe = 1'b1, eOe = 1'b1, eWe = 1'b1, eDoe = 1'b0, eBusy = 1'b0, eDone = 1'b0;
         if (mKind[g] == 1) begin
            eBusy = 1'b1;
            if (mAge[g] <= w) begin
               eCe = 1'b0;
               eOe = 1'b0;
            end else eDone = 1'b1;
         end else if (mKind[g] == 2) begin
            eBusy = 1'b1;
            if (mAge[g] <= w + 1) begin
               eCe  = 1'b0;
               eDoe = 1'b1;
               if (mAge[g] >= 1 && mAge[g] <= w) eWe = 1'b0;
            end else eDone = 1'b1;
         end
         checkOutput($sformatf("ce_n[%0d]", g), 32'(ceN[g]), 32'(eCe));
         checkOutput($sformatf("oe_n[%0d]", g), 32'(oeN[g]), 32'(eOe));
         checkOutput($sformatf("we_n[%0d]", g), 32'(weN[g]), 32'(eWe));
         checkOutput($sformatf("data_oe[%0d]", g), 32'(dataOe[g]), 32'(eDoe));
         checkOutput($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(eBusy));
         checkOutput($sformatf("done[%0d]", g), 32'(done[g]), 32'(eDone));
         checkOutput($sformatf("mar[%0d]", g), 32'(marO[g]), 32'(mMar[g]));
         checkOutput($sformatf("mdr[%0d]", g), 32'(mdrO[g]), 32'(mMdr[g]));
         checkOutput($sformatf("data_to_sram[%0d]", g), 32'(dtsO[g]), 32'(mMdr[g]));
         checkOutput($sformatf("we_oe_excl[%0d]", g), 32'(!(weN[g] == 1'b0 && oeN[g] == 1'b0)), 32'd1);
      end
   endtask

   task automatic startTrack();
      for (int g = 0; g < 3; g++) begin
         cyc[g]    = 0;
         doneAt[g] = 0;
         oeLow[g]  = 0;
         weLow[g]  = 0;
      end
   endtask

   // One clock: advance model at the edge, then sample DUT 1 unit later
   task automatic tick();
      @(posedge Clk);
      modelStep();
      #1;
      checkAll();
      for (int g = 0; g < 3; g++) begin
         cyc[g]++;
         if (!oeN[g]) oeLow[g]++;
         if (!weN[g]) weLow[g]++;
         if (done[g] && doneAt[g] == 0) doneAt[g] = cyc[g];
      end
   endtask

   task automatic applyStimulus(input logic [15:0] b, input logic lm, input logic ld,
                                input logic [2:0] rd, input logic [2:0] wr, input logic [15:0] d);
      bus   = b;
      ldMar = lm;
      ldMdr = ld;
      dfs   = d;
      for (int g = 0; g < 3; g++) begin
         memR[g] = rd[g];
         memW[g] = wr[g];
      end
      tick();
      ldMar = 1'b0;
      ldMdr = 1'b0;
      for (int g = 0; g < 3; g++) begin
         memR[g] = 1'b0;
         memW[g] = 1'b0;
      end
   endtask

   task automatic runIdle(input int maxC);
      for (int i = 0; i < maxC; i++) begin
         tick();
         if (mKind[0] == 0 && mKind[1] == 0 && mKind[2] == 0) break;
      end
   endtask

   task automatic asyncReset();
      #3 resetN = 1'b0;
      #1 modelReset();
      checkAll();
      @(negedge Clk);
      resetN = 1'b1;
   endtask

   initial begin
      resetN = 1'b0;
      bus    = 16'h0000;
      ldMar  = 1'b0;
      ldMdr  = 1'b0;
      dfs    = 16'h0000;
      for (int g = 0; g < 3; g++) begin
         memR[g] = 1'b0;
         memW[g] = 1'b0;
      end
      #1 modelReset();
      checkAll();
      @(negedge Clk);
      resetN = 1'b1;

      $display("[TB] directed read");
      applyStimulus(16'h0042, 1'b1, 1'b0, 3'b000, 3'b000, 16'hBEEF);
      startTrack();
      applyStimulus(16'h0000, 1'b0, 1'b0, 3'b111, 3'b000, 16'hBEEF);
      runIdle(40);
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("rd_done_cycle[%0d]", g), doneAt[g], wOf(g) + 2);
         checkOutput($sformatf("rd_oe_low[%0d]", g), oeLow[g], wOf(g) + 1);
         checkOutput($sformatf("rd_mdr[%0d]", g), 32'(mdrO[g]), 32'hBEEF);
         checkOutput($sformatf("rd_mar[%0d]", g), 32'(marO[g]), 32'h0042);
      end

      $display("[TB] directed write");
      applyStimulus(16'h1234, 1'b1, 1'b0, 3'b000, 3'b000, 16'h0000);
      applyStimulus(16'hA5A5, 1'b0, 1'b1, 3'b000, 3'b000, 16'h0000);
      startTrack();
      applyStimulus(16'h0000, 1'b0, 1'b0, 3'b000, 3'b111, 16'h0000);
      runIdle(40);
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("wr_done_cycle[%0d]", g), doneAt[g], wOf(g) + 3);
         checkOutput($sformatf("wr_we_low[%0d]", g), weLow[g], wOf(g));
         checkOutput($sformatf("wr_data[%0d]", g), 32'(dtsO[g]), 32'hA5A5);
      end

      $display("[TB] read/write collision");
      startTrack();
      applyStimulus(16'h0000, 1'b0, 1'b0, 3'b111, 3'b111, 16'h3C3C);
      runIdle(40);
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("coll_we_low[%0d]", g), weLow[g], 0);
         checkOutput($sformatf("coll_done_cycle[%0d]", g), doneAt[g], wOf(g) + 2);
      end

      $display("[TB] busy blocking");
      startTrack();
      applyStimulus(16'h0000, 1'b0, 1'b0, 3'b111, 3'b000, 16'h5A5A);
      applyStimulus(16'hFFFF, 1'b1, 1'b0, 3'b000, 3'b111, 16'h5A5A);
      applyStimulus(16'h1111, 1'b0, 1'b1, 3'b000, 3'b000, 16'h5A5A);
      runIdle(40);
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("blk_mar[%0d]", g), 32'(marO[g]), 32'h1234);
         checkOutput($sformatf("blk_mdr[%0d]", g), 32'(mdrO[g]), 32'h5A5A);
         checkOutput($sformatf("blk_we_low[%0d]", g), weLow[g], 0);
      end

      $display("[TB] reset during write pulse");
      applyStimulus(16'h0000, 1'b0, 1'b0, 3'b000, 3'b111, 16'h0000);
      tick();
      asyncReset();
      startTrack();
      for (int i = 0; i < 20; i++) tick();
      for (int g = 0; g < 3; g++)
         checkOutput($sformatf("rst_no_done[%0d]", g), doneAt[g], 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         bus   = 16'($urandom);
         dfs   = 16'($urandom);
         ldMar = ($urandom_range(0, 3) == 0);
         ldMdr = ($urandom_range(0, 3) == 0);
         for (int g = 0; g < 3; g++) begin
            memR[g] = ($urandom_range(0, 3) == 0);
            memW[g] = ($urandom_range(0, 3) == 0);
         end
         tick();
         if ($urandom_range(0, 79) == 0) asyncReset();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
